rsp_tx_fsm: RTL and testbench

- Response encoder and transmitter: the outgoing counterpart of the command decoder that parses received UART frames.
- On `transmit`, pulls N result bytes from the processors' result FIFO and frames them as a response packet.
- Serializes the packet 8N1 on the `tx` line.
- Sits between the processors' result output and the top-level `tx` pin.

---
 rtl/global_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 75 +++++++
 rtl/rsp_tx_fsm.sv | 174 +++++++++++++++++
 tb/tb_rsp_tx_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// Shared types and constants for the command/response path.
// Checksum feature selected by RSP_CHECKSUM_EN.
package global_pkg;

  localparam int NIBBLE = 4;

  typedef logic [7:0]        data_t;
  typedef logic [NIBBLE-1:0] nibble_t;

  localparam data_t RSP_HEADER = 8'hFE;
  localparam data_t RSP_FOOTER = 8'hEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_CMD,
    S_DATA,
    S_CHK,
    S_FTR,
    S_DONE
  } rsp_state_t;

  function automatic data_t len_byte(input nibble_t n);
    return data_t'(n);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// byte_done pulses in the final cycle of the stop bit.
module uart_tx_byte
  import global_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  data_t byte_in,
  output logic  tx,
  output logic  byte_done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic          act_q, act_d;
  logic [9:0]    sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end   = act_q && (cnt_q == LAST);
  assign byte_done = bit_end && (idx_q == 4'd9);
  assign tx        = tx_q;

  always_comb begin
    act_d = act_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    tx_d  = tx_q;
    if (load) begin
      act_d = 1'b1;
      sh_d  = {1'b1, byte_in, 1'b0};
      cnt_d = '0;
      idx_d = '0;
      tx_d  = 1'b0;
    end else if (act_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (idx_q == 4'd9) begin
          act_d = 1'b0;
          tx_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          sh_d  = {1'b1, sh_q[9:1]};
          tx_d  = sh_q[1];
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q <= 1'b0;
      sh_q  <= '1;
      cnt_q <= '0;
      idx_q <= '0;
      tx_q  <= 1'b1;
    end else begin
      act_q <= act_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      tx_q  <= tx_d;
    end
  end

endmodule

// File: rtl/rsp_tx_fsm.sv
// Response framer: FE, len, cmd, N data bytes, [checksum], EF over 8N1.
// Checksum byte enabled by RSP_CHECKSUM_EN.
module rsp_tx_fsm
  import global_pkg::*;
#(
  parameter int    BAUD_DIV = 5208,
  parameter data_t RSP_CMD  = 8'h05
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    transmit,
  input  nibble_t N,
  input  data_t   result_data,
  input  logic    result_empty,
  output logic    pop_result,
  output logic    tx,
  output logic    busy,
  output logic    done
);

`ifdef RSP_CHECKSUM_EN
  localparam rsp_state_t S_POST = S_CHK;
`else
  localparam rsp_state_t S_POST = S_FTR;
`endif

  rsp_state_t st_q, st_d;
  nibble_t    n_q, n_d;
  nibble_t    rem_q, rem_d;
  logic       sent_q, sent_d;
  logic [1:0] ph_q, ph_d;
`ifdef RSP_CHECKSUM_EN
  data_t      chk_q, chk_d;
`endif

  logic  load;
  logic  byte_done;
  data_t byte_in;

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .byte_in   (byte_in),
    .tx        (tx),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      n_q    <= '0;
      rem_q  <= '0;
      sent_q <= 1'b0;
      ph_q   <= '0;
`ifdef RSP_CHECKSUM_EN
      chk_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      n_q    <= n_d;
      rem_q  <= rem_d;
      sent_q <= sent_d;
      ph_q   <= ph_d;
`ifdef RSP_CHECKSUM_EN
      chk_q  <= chk_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    n_d    = n_q;
    rem_d  = rem_q;
    sent_d = sent_q;
    ph_d   = ph_q;
`ifdef RSP_CHECKSUM_EN
    chk_d  = chk_q;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (transmit) begin
          st_d   = S_HDR;
          n_d    = N;
          rem_d  = N;
          sent_d = 1'b0;
          ph_d   = '0;
`ifdef RSP_CHECKSUM_EN
          chk_d  = len_byte(N) ^ RSP_CMD;
`endif
        end
      end
      // ph 0: wait for data and pop, 1: load, 2: shifting
      S_DATA: begin
        unique case (ph_q)
          2'd0: if (!result_empty) ph_d = 2'd1;
          2'd1: begin
            ph_d  = 2'd2;
`ifdef RSP_CHECKSUM_EN
            chk_d = chk_q ^ result_data;
`endif
          end
          2'd2: begin
            if (byte_done) begin
              ph_d  = 2'd0;
              rem_d = rem_q - 1'b1;
              if (rem_q == nibble_t'(1)) st_d = S_POST;
            end
          end
          default: ph_d = 2'd0;
        endcase
      end
      S_DONE: st_d = S_IDLE;
      default: begin
        if (!sent_q) begin
          sent_d = 1'b1;
        end else if (byte_done) begin
          sent_d = 1'b0;
          unique case (st_q)
            S_HDR:   st_d = S_LEN;
            S_LEN:   st_d = S_CMD;
            S_CMD:   st_d = (n_q == '0) ? S_POST : S_DATA;
            S_CHK:   st_d = S_FTR;
            default: st_d = S_DONE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    pop_result = 1'b0;
    load       = 1'b0;
    byte_in    = RSP_HEADER;
    done       = 1'b0;
    busy       = (st_q != S_IDLE);
    unique case (st_q)
      S_HDR: begin
        load    = !sent_q;
        byte_in = RSP_HEADER;
      end
      S_LEN: begin
        load    = !sent_q;
        byte_in = len_byte(n_q);
      end
      S_CMD: begin
        load    = !sent_q;
        byte_in = RSP_CMD;
      end
      S_DATA: begin
        pop_result = (ph_q == 2'd0) && !result_empty;
        load       = (ph_q == 2'd1);
        byte_in    = result_data;
      end
      S_CHK: begin
        load    = !sent_q;
`ifdef RSP_CHECKSUM_EN
        byte_in = chk_q;
`else
        byte_in = RSP_FOOTER;
`endif
      end
      S_FTR: begin
        load    = !sent_q;
        byte_in = RSP_FOOTER;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rsp_tx_fsm.sv
// Bench for rsp_tx_fsm: UART monitor, FIFO model, packet reference model.
// Define RSP_CHECKSUM_EN for both bench and RTL to cover the checksum build.
module tb_rsp_tx_fsm;
  import global_pkg::*;

  localparam int BD = 4;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    transmit = 1'b0;
  nibble_t n_in = '0;
  data_t   result_data;
  logic    result_empty;
  logic    pop_result, tx, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void check(input string tag,
                                input logic [31:0] obs,
                                input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  always #5 clk = ~clk;

  rsp_tx_fsm #(
    .BAUD_DIV (BD),
    .RSP_CMD  (8'h05)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .transmit     (transmit),
    .N            (n_in),
    .result_data  (result_data),
    .result_empty (result_empty),
    .pop_result   (pop_result),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  data_t      mem [32];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;
  logic       push_v = 1'b0;
  data_t      push_d = '0;
  logic       flush = 1'b0;

  assign result_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_v) begin
        mem[wr_ptr] <= push_d;
        wr_ptr <= wr_ptr + 5'd1;
      end
      if (pop_result === 1'b1) begin
        result_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 5'd1;
      end
    end
  end

  int pop_cnt  = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (pop_result === 1'b1) pop_cnt <= pop_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  data_t rx[$];

  initial begin
    data_t b;
    bit ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        repeat (BD / 2) @(negedge clk);
        ok &= rst;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx;
          ok &= rst;
        end
        repeat (BD) @(negedge clk);
        ok &= rst & (tx === 1'b1);
        if (ok) rx.push_back(b);
      end
    end
  end

  data_t pkt[$];
  data_t pend[$];

  function automatic void build_exp(input int n, output data_t e[$]);
    data_t x;
    e = {};
    e.push_back(8'hFE);
    e.push_back(data_t'(n));
    e.push_back(8'h05);
    x = data_t'(n) ^ 8'h05;
    foreach (pkt[i]) begin
      e.push_back(pkt[i]);
      x ^= pkt[i];
    end
`ifdef RSP_CHECKSUM_EN
    e.push_back(x);
`endif
    e.push_back(8'hEF);
  endfunction

  task automatic push1(input data_t v);
    push_v = 1'b1;
    push_d = v;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic send(input int n, input int pre, input int dly0,
                      input bit repulse, input bit idle_chk);
    data_t e[$];
    int t, next_t, p0, d0;
    bit busy_ok;
    build_exp(n, e);
    pend = pkt;
    for (int i = 0; i < pre; i++) push1(pend.pop_front());
    rx.delete();
    p0 = pop_cnt;
    d0 = done_cnt;
    transmit = 1'b1;
    n_in = nibble_t'(n);
    @(negedge clk);
    transmit = 1'b0;
    n_in = nibble_t'($urandom);
    t = 0;
    next_t = dly0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && t < 6000) begin
      push_v = 1'b0;
      transmit = 1'b0;
      if (pend.size() > 0 && t >= next_t) begin
        push_v = 1'b1;
        push_d = pend.pop_front();
        next_t = t + int'($urandom_range(0, 80));
      end
      if (repulse && t == 60) begin
        transmit = 1'b1;
        n_in = 4'd5;
      end
      if (idle_chk && t == 190) begin
        check("stall_tx_idle", tx, 1'b1);
        check("stall_rx_bytes", rx.size(), 3);
        check("stall_no_pop", pop_cnt - p0, 0);
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    push_v = 1'b0;
    transmit = 1'b0;
    check("done_timeout", t < 6000, 1'b1);
    check("busy_held", busy_ok, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_drop", busy, 1'b0);
    check("done_count", done_cnt - d0, 1);
    check("pop_count", pop_cnt - p0, n);
    check("byte_count", rx.size(), e.size());
    for (int i = 0; i < e.size() && i < rx.size(); i++)
      check("pkt_byte", rx[i], e[i]);
  endtask

  initial begin
    int p0, d0, t, n;
    bit idle_ok;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pop", pop_result, 1'b0);
    rst = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_quiet", idle_ok, 1'b1);
    check("idle_no_pop", pop_cnt, 0);

    pkt = {8'h12, 8'h34};
    send(2, 2, 0, 1'b0, 1'b0);

    pkt = {};
    send(0, 0, 0, 1'b0, 1'b0);

    pkt = {8'h7A};
    send(1, 0, 200, 1'b0, 1'b1);

    pkt = {8'hC3, 8'h5D};
    send(2, 2, 0, 1'b1, 1'b0);

    pkt = {8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) push1(pkt[i]);
    p0 = pop_cnt;
    d0 = done_cnt;
    transmit = 1'b1;
    n_in = 4'd3;
    @(negedge clk);
    transmit = 1'b0;
    t = 0;
    while (pop_cnt == p0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_data", t < 2000, 1'b1);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    flush = 1'b1;
    repeat (5) @(negedge clk);
    flush = 1'b0;
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_tx_idle", tx, 1'b1);

    pkt = {8'hA5, 8'h0F, 8'hF0};
    send(3, 3, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(0, 15));
      pkt = {};
      for (int i = 0; i < n; i++) pkt.push_back(data_t'($urandom));
      send(n, int'($urandom_range(0, n)), int'($urandom_range(0, 100)),
           1'(k % 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
